// File: rtl/riscv_v_reduct_pipe_pkg.sv
// Shared types and helpers for the vector reduction pipe.
// Latency: n/a (package). Backpressure: n/a.
// Holds the op/SEW enums, SEW identity constants, the sign/zero extender,
// the add/min/max fold step and the accumulator width function.
// Optional feature macro: RISCV_V_REDUCT_OF_EN (selects the wide accumulator in the top level).
package riscv_v_reduct_pipe_pkg;

  typedef enum logic [1:0] {
    OP_SUM  = 2'd0,
    OP_MAX  = 2'd1,
    OP_MIN  = 2'd2,
    OP_RSVD = 2'd3   // folds as SUM
  } riscv_v_reduct_op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } riscv_v_sew_e;

  // Working width of the helpers; callers truncate to their accumulator width.
  localparam int XW = 128;

  function automatic logic [63:0] riscv_v_sew_umax(riscv_v_sew_e sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_00FF;
      SEW_16:  return 64'h0000_0000_0000_FFFF;
      SEW_32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] riscv_v_sew_smax(riscv_v_sew_e sew);
    return riscv_v_sew_umax(sew) >> 1;
  endfunction

  // Only the SEW sign bit set.
  function automatic logic [63:0] riscv_v_sew_smin(riscv_v_sew_e sew);
    return riscv_v_sew_umax(sew) ^ riscv_v_sew_smax(sew);
  endfunction

  // Low SEW bits of v, sign- or zero-extended to XW bits.
  function automatic logic [XW-1:0] riscv_v_sew_ext(logic [63:0] v, riscv_v_sew_e sew, logic sgn);
    logic [63:0] um;
    um = riscv_v_sew_umax(sew);
    if (sgn && ((v & riscv_v_sew_smin(sew)) != 64'd0))
      return {64'hFFFF_FFFF_FFFF_FFFF, v | ~um};
    return {64'd0, v & um};
  endfunction

  // Raw SEW value a masked-off element is replaced with.
  function automatic logic [63:0] riscv_v_ident(riscv_v_reduct_op_e op, riscv_v_sew_e sew, logic sgn);
    case (op)
      OP_MAX:  return sgn ? riscv_v_sew_smin(sew) : 64'd0;
      OP_MIN:  return sgn ? riscv_v_sew_smax(sew) : riscv_v_sew_umax(sew);
      default: return 64'd0;
    endcase
  endfunction

  // One reduction step on extended operands. Unsigned elements are zero-extended
  // with headroom, so a signed compare is correct for both signednesses.
  function automatic logic [XW-1:0] riscv_v_fold(riscv_v_reduct_op_e op, logic [XW-1:0] a, logic [XW-1:0] b);
    case (op)
      OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      default: return a + b;
    endcase
  endfunction

  // Exact-sum accumulator width: 64 data bits, growth for every element, one sign bit.
  function automatic int riscv_v_acc_w(int data_bytes, int max_beats);
    return 64 + $clog2(data_bytes * max_beats) + 1;
  endfunction

endpackage

// File: rtl/riscv_v_reduct_pipe_if.sv
// Beat input / scalar result bundle of the vector reduction pipe.
// Latency: n/a (wiring). Backpressure: in_valid/in_ready on beats, out_valid/out_ready on results.
// Ports: flush, in_* beat channel with per-packet op/is_signed/sew/scalar_init, out_* result channel.
// slave = the reduction unit, master = the issuing execute stage.
interface riscv_v_reduct_pipe_if
  import riscv_v_reduct_pipe_pkg::*;
#(
  parameter int DATA_BYTES = 16,
  parameter int BEAT_CNT_W = 4
) ();

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_BYTES*8-1:0] in_data;
  logic [DATA_BYTES-1:0]   in_mask;
  logic                    in_first;
  logic                    in_last;
  riscv_v_reduct_op_e      op;
  logic                    is_signed;
  riscv_v_sew_e            sew;
  logic [63:0]             scalar_init;
  logic                    out_valid;
  logic                    out_ready;
  logic [63:0]             out_data;
  logic                    out_of;
  logic [BEAT_CNT_W-1:0]   out_beats;

  modport slave (
    input  flush, in_valid, in_data, in_mask, in_first, in_last,
           op, is_signed, sew, scalar_init, out_ready,
    output in_ready, out_valid, out_data, out_of, out_beats
  );

  modport master (
    output flush, in_valid, in_data, in_mask, in_first, in_last,
           op, is_signed, sew, scalar_init, out_ready,
    input  in_ready, out_valid, out_data, out_of, out_beats
  );

endinterface

// File: rtl/riscv_v_reduct_tree.sv
// SEW-aware lane tree: folds one beat into a single extended partial (add/max/min).
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: data/mask beat, op/is_signed/sew controls, part = extended ACC_W-bit partial.
module riscv_v_reduct_tree
  import riscv_v_reduct_pipe_pkg::*;
#(
  parameter int DATA_BYTES = 16,
  parameter int ACC_W      = 72
) (
  input  logic [DATA_BYTES*8-1:0] data,
  input  logic [DATA_BYTES-1:0]   mask,
  input  riscv_v_reduct_op_e      op,
  input  logic                    is_signed,
  input  riscv_v_sew_e            sew,
  output logic [ACC_W-1:0]        part
);

  localparam int LVLS = $clog2(DATA_BYTES);

  logic [ACC_W-1:0] lane [DATA_BYTES];
  logic [ACC_W-1:0] ident;
  logic [63:0]      raw;
  logic [LVLS-1:0]  mbit;
  int               ew;
  int               n_el;

  always_comb begin
    ew    = 8 << sew;
    n_el  = DATA_BYTES >> sew;
    ident = ACC_W'(riscv_v_sew_ext(riscv_v_ident(op, sew, is_signed), sew, is_signed));
    raw   = '0;
    mbit  = '0;
    // Lanes beyond the element count of this SEW hold the identity, so one
    // fixed tree of DATA_BYTES leaves serves every element width.
    for (int e = 0; e < DATA_BYTES; e++) begin
      lane[e] = ident;
      if (e < n_el) begin
        mbit = LVLS'(e << sew);          // element e is governed by its lowest byte's mask bit
        raw  = 64'(data >> (e * ew));
        if (mask[mbit])
          lane[e] = ACC_W'(riscv_v_sew_ext(raw, sew, is_signed));
      end
    end
    // Pairwise fold, in place: level l leaves DATA_BYTES>>(l+1) live lanes.
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < DATA_BYTES / 2; i++) begin
        if (i < (DATA_BYTES >> (l + 1)))
          lane[i] = ACC_W'(riscv_v_fold(op, XW'($signed(lane[2*i])), XW'($signed(lane[2*i+1]))));
      end
    end
    part = lane[0];
  end

endmodule

// File: rtl/riscv_v_reduct_pipe.sv
// Multi-beat vredsum/vredmax/vredmin unit: per-beat lane tree, cross-beat accumulator, one scalar per packet.
// Latency: result valid two edges after the last beat is accepted; one beat per cycle while accumulating.
// Backpressure: in_ready drops from the last beat until the result handshakes; outputs hold while out_ready is low.
// Ports: clk, rst_n (async active low), bus (riscv_v_reduct_pipe_if.slave).
// Macro RISCV_V_REDUCT_OF_EN: wide exact accumulator and live out_of; undefined gives a wrapping accumulator and out_of=0.
module riscv_v_reduct_pipe
  import riscv_v_reduct_pipe_pkg::*;
#(
  parameter int DATA_BYTES = 16,
  parameter int MAX_BEATS  = 8,
  parameter int BEAT_CNT_W = $clog2(MAX_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_v_reduct_pipe_if.slave bus
);

`ifdef RISCV_V_REDUCT_OF_EN
  localparam int ACC_W = riscv_v_acc_w(DATA_BYTES, MAX_BEATS);
`else
  // 64-bit wrap plus one guard bit so 64-bit unsigned MAX/MIN still compare correctly.
  localparam int ACC_W = 65;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_e;

  state_e                 state;
  riscv_v_reduct_op_e     op_q;
  logic                   sgn_q;
  riscv_v_sew_e           sew_q;
  logic [BEAT_CNT_W-1:0]  cnt;
  logic                   s1_vld, s1_first, s1_last;
  logic [ACC_W-1:0]       s1_part, s1_seed, acc;
  logic                   out_vld_q, out_of_q;
  logic [63:0]            out_dat_q;
  logic [BEAT_CNT_W-1:0]  out_beats_q;

  logic                   is_idle, in_rdy, accept, last_eff;
  riscv_v_reduct_op_e     cur_op;
  logic                   cur_sgn;
  riscv_v_sew_e           cur_sew;
  logic [BEAT_CNT_W-1:0]  cnt_nxt;
  logic [ACC_W-1:0]       part, acc_base, acc_nxt;
  logic [63:0]            res;
  logic                   res_of;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_dat_q;
  assign bus.out_of    = out_of_q;
  assign bus.out_beats = out_beats_q;

  always_comb begin
    is_idle  = (state == S_IDLE);
    in_rdy   = is_idle || (state == S_ACCUM);
    // In IDLE a beat without in_first is swallowed (ready but not accepted).
    accept   = bus.in_valid && in_rdy && (!is_idle || bus.in_first);
    // The first beat folds with its own controls; later beats use the sampled ones.
    cur_op   = is_idle ? bus.op        : op_q;
    cur_sgn  = is_idle ? bus.is_signed : sgn_q;
    cur_sew  = is_idle ? bus.sew       : sew_q;
    cnt_nxt  = is_idle ? BEAT_CNT_W'(1) : cnt + BEAT_CNT_W'(1);
    last_eff = bus.in_last || (cnt_nxt == BEAT_CNT_W'(MAX_BEATS));
  end

  riscv_v_reduct_tree #(
    .DATA_BYTES (DATA_BYTES),
    .ACC_W      (ACC_W)
  ) u_tree (
    .data      (bus.in_data),
    .mask      (bus.in_mask),
    .op        (cur_op),
    .is_signed (cur_sgn),
    .sew       (cur_sew),
    .part      (part)
  );

  always_comb begin
    acc_base = s1_first ? s1_seed : acc;
    acc_nxt  = ACC_W'(riscv_v_fold(op_q, XW'($signed(acc_base)), XW'($signed(s1_part))));
    res      = acc_nxt[63:0] & riscv_v_sew_umax(sew_q);
`ifdef RISCV_V_REDUCT_OF_EN
    // The exact sum is representable iff re-extending its SEW truncation gives it back.
    res_of   = (op_q != OP_MAX) && (op_q != OP_MIN) &&
               (ACC_W'(riscv_v_sew_ext(res, sew_q, sgn_q)) != acc_nxt);
`else
    res_of   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_SUM;
      sgn_q       <= 1'b0;
      sew_q       <= SEW_8;
      cnt         <= '0;
      s1_vld      <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_part     <= '0;
      s1_seed     <= '0;
      acc         <= '0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_of_q    <= 1'b0;
      out_beats_q <= '0;
    end else if (bus.flush) begin
      state       <= S_IDLE;
      cnt         <= '0;
      s1_vld      <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_part     <= '0;
      s1_seed     <= '0;
      acc         <= '0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_of_q    <= 1'b0;
      out_beats_q <= '0;
    end else begin
      // Stage 1: register the folded beat at the accept edge.
      s1_vld <= accept;
      if (accept) begin
        s1_part  <= part;
        s1_seed  <= ACC_W'(riscv_v_sew_ext(bus.scalar_init, cur_sew, cur_sgn));
        s1_first <= is_idle;
        s1_last  <= last_eff;
        cnt      <= cnt_nxt;
        if (is_idle) begin
          op_q  <= bus.op;
          sgn_q <= bus.is_signed;
          sew_q <= bus.sew;
        end
      end
      // Stage 2: fold into the accumulator; capture the result on the last beat.
      if (s1_vld) begin
        acc <= acc_nxt;
        if (s1_last) begin
          out_dat_q   <= res;
          out_of_q    <= res_of;
          out_beats_q <= cnt;
        end
      end
      case (state)
        S_IDLE:  if (accept) state <= last_eff ? S_DRAIN : S_ACCUM;
        S_ACCUM: if (accept && last_eff) state <= S_DRAIN;
        S_DRAIN: begin
          state     <= S_DONE;
          out_vld_q <= 1'b1;
        end
        S_DONE:  if (bus.out_ready) begin
          state     <= S_IDLE;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_v_reduct_pipe.sv
// Directed bench for riscv_v_reduct_pipe with DATA_BYTES=16, MAX_BEATS=8.
// Latency: n/a. Backpressure: exercises out_ready stalls, flush and async reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_riscv_v_reduct_pipe;
  import riscv_v_reduct_pipe_pkg::*;

  localparam int DB = 16;
  localparam int MB = 8;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic exp_of2;

  always #5 clk = ~clk;

  riscv_v_reduct_pipe_if #(.DATA_BYTES(DB), .BEAT_CNT_W(BW)) bus ();

  riscv_v_reduct_pipe #(
    .DATA_BYTES (DB),
    .MAX_BEATS  (MB),
    .BEAT_CNT_W (BW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts on a falling edge, presents one beat, returns on the falling edge after its accept edge.
  task automatic beat(input string tag, input logic [127:0] d, input logic [15:0] m,
                      input logic f, input logic l, input riscv_v_reduct_op_e o,
                      input logic s, input riscv_v_sew_e w, input logic [63:0] init);
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_mask     = m;
    bus.in_first    = f;
    bus.in_last     = l;
    bus.op          = o;
    bus.is_signed   = s;
    bus.sew         = w;
    bus.scalar_init = init;
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Called on the falling edge right after the last beat's accept edge.
  task automatic expect_result(input string tag, input logic [63:0] d, input logic of,
                               input logic [BW-1:0] nb, input logic consume);
    chk({tag, "_vld_early"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"},   64'(bus.out_valid), 64'd1);
    chk({tag, "_data"},  bus.out_data, d);
    chk({tag, "_of"},    64'(bus.out_of), 64'(of));
    chk({tag, "_beats"}, 64'(bus.out_beats), 64'(nb));
    if (consume) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_vld_clr"}, 64'(bus.out_valid), 64'd0);
    end
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_mask     = '0;
    bus.in_first    = 1'b0;
    bus.in_last     = 1'b0;
    bus.op          = OP_SUM;
    bus.is_signed   = 1'b0;
    bus.sew         = SEW_8;
    bus.scalar_init = '0;
    bus.out_ready   = 1'b0;
`ifdef RISCV_V_REDUCT_OF_EN
    exp_of2 = 1'b1;
`else
    exp_of2 = 1'b0;
`endif

    // Reset state.
    #1;
    chk("rst_vld",   64'(bus.out_valid), 64'd0);
    chk("rst_data",  bus.out_data, 64'd0);
    chk("rst_of",    64'(bus.out_of), 64'd0);
    chk("rst_beats", 64'(bus.out_beats), 64'd0);
    chk("rst_rdy",   64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: SEW8 unsigned SUM, 16 x 1 + 5 = 0x15.
    beat("t1", {16{8'h01}}, 16'hFFFF, 1'b1, 1'b1, OP_SUM, 1'b0, SEW_8, 64'd5);
    expect_result("t1", 64'h15, 1'b0, 4'd1, 1'b1);

    // 2: SEW8 unsigned SUM, 16 x 0xFF = 0xFF0 -> wraps to 0xF0.
    beat("t2", {16{8'hFF}}, 16'hFFFF, 1'b1, 1'b1, OP_SUM, 1'b0, SEW_8, 64'd0);
    expect_result("t2", 64'hF0, exp_of2, 4'd1, 1'b1);

    // 3: SEW16 signed MAX over 3 beats; 0x7FFF is masked off, -5 and 7 active.
    beat("t3a", {{7{16'h8000}}, 16'hFFFB}, 16'hFFFF, 1'b1, 1'b0, OP_MAX, 1'b1, SEW_16, 64'h8000);
    beat("t3b", {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h7FFF, 16'hFFF0, 16'hFFF0, 16'h0007},
         16'hFFBF, 1'b0, 1'b0, OP_MAX, 1'b1, SEW_16, 64'h0);
    beat("t3c", {8{16'h7FFF}}, 16'h0000, 1'b0, 1'b1, OP_MAX, 1'b1, SEW_16, 64'h0);
    expect_result("t3", 64'h0007, 1'b0, 4'd3, 1'b1);

    // MAX_BEATS beats without in_last: the eighth is treated as last. 8*16 = 0x80.
    for (int i = 0; i < MB; i++)
      beat("tmax", {16{8'h01}}, 16'hFFFF, (i == 0), 1'b0, OP_SUM, 1'b0, SEW_8, 64'd0);
    expect_result("tmax", 64'h80, 1'b0, 4'd8, 1'b1);

    // 4: SEW32 unsigned MIN, all masked: result is the low 32 bits of the seed.
    beat("t4", {4{32'h0000_0001}}, 16'h0000, 1'b1, 1'b1, OP_MIN, 1'b0, SEW_32, 64'hDEAD_BEEF_0000_1234);
    expect_result("t4", 64'h0000_1234, 1'b0, 4'd1, 1'b0);

    // 5: hold out_ready low with the next first beat waiting.
    bus.in_valid    = 1'b1;
    bus.in_data     = {64'd3, 64'd4};
    bus.in_mask     = 16'hFFFF;
    bus.in_first    = 1'b1;
    bus.in_last     = 1'b1;
    bus.op          = OP_SUM;
    bus.is_signed   = 1'b0;
    bus.sew         = SEW_64;
    bus.scalar_init = 64'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_vld",  64'(bus.out_valid), 64'd1);
      chk("t5_hold_data", bus.out_data, 64'h0000_1234);
      chk("t5_hold_rdy",  64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t5_hs_vld", 64'(bus.out_valid), 64'd0);
    chk("t5_hs_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_result("t5", 64'd17, 1'b0, 4'd1, 1'b1);

    // 6: flush after two beats, a stray non-first beat, then a fresh packet.
    beat("t6a", {16{8'h03}}, 16'hFFFF, 1'b1, 1'b0, OP_SUM, 1'b0, SEW_8, 64'd1);
    beat("t6b", {16{8'h03}}, 16'hFFFF, 1'b0, 1'b0, OP_SUM, 1'b0, SEW_8, 64'd0);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("t6_fl_vld",   64'(bus.out_valid), 64'd0);
    chk("t6_fl_beats", 64'(bus.out_beats), 64'd0);
    chk("t6_fl_rdy",   64'(bus.in_ready), 64'd1);
    beat("t6_drop", {16{8'h05}}, 16'hFFFF, 1'b0, 1'b1, OP_SUM, 1'b0, SEW_8, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_drop_vld", 64'(bus.out_valid), 64'd0);
    beat("t6", {16{8'h02}}, 16'hFFFF, 1'b1, 1'b1, OP_SUM, 1'b0, SEW_8, 64'd0);
    expect_result("t6", 64'h20, 1'b0, 4'd1, 1'b1);

    // Async reset in the middle of a packet, away from any clock edge.
    beat("t7", {16{8'h01}}, 16'hFFFF, 1'b1, 1'b0, OP_SUM, 1'b0, SEW_8, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_vld",   64'(bus.out_valid), 64'd0);
    chk("t7_rst_data",  bus.out_data, 64'd0);
    chk("t7_rst_beats", 64'(bus.out_beats), 64'd0);
    chk("t7_rst_rdy",   64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
